// File: rtl/cl_cfg_mux.sv
// AXI4-Lite to cfg-bus slot mux: decodes each access to one of NUM_SLV slots and holds it until that slot acks.
// Optional ack timeout is enabled with `define CFG_MUX_TIMEOUT_EN.
module cl_cfg_mux #(
  parameter int          NUM_SLV     = 16,
  parameter int          SLOT_SHIFT  = 8,
  parameter logic [31:0] DEAD_DATA   = 32'hDEAD_BEEF,
  parameter int          TIMEOUT_CYC = 1024
) (
  input  logic                 clk,
  input  logic                 sync_rst_n,
  input  logic                 flr_assert,
  input  logic [31:0]          s_awaddr,
  input  logic                 s_awvalid,
  output logic                 s_awready,
  input  logic [31:0]          s_wdata,
  input  logic [3:0]           s_wstrb,
  input  logic                 s_wvalid,
  output logic                 s_wready,
  output logic [1:0]           s_bresp,
  output logic                 s_bvalid,
  input  logic                 s_bready,
  input  logic [31:0]          s_araddr,
  input  logic                 s_arvalid,
  output logic                 s_arready,
  output logic [31:0]          s_rdata,
  output logic [1:0]           s_rresp,
  output logic                 s_rvalid,
  input  logic                 s_rready,
  output logic [31:0]          cfg_addr,
  output logic [31:0]          cfg_wdata,
  output logic [3:0]           cfg_wstrb,
  output logic [NUM_SLV-1:0]   cfg_wr,
  output logic [NUM_SLV-1:0]   cfg_rd,
  input  logic [NUM_SLV-1:0]   cfg_ack,
  input  logic [32*NUM_SLV-1:0] cfg_rdata
);

  localparam int SEL_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_RESP} state_t;

  state_t             state_reg, state_next;
  logic               wr_reg;
  logic               last_wr_reg;
  logic               mapped_reg;
  logic [SEL_W-1:0]   slot_reg;
  logic [31:0]        addr_reg;
  logic [31:0]        wdata_reg;
  logic [3:0]         wstrb_reg;
  logic [31:0]        rdata_reg;
  logic [1:0]         resp_reg;

  logic               wr_cand, rd_cand;
  logic               grant_wr, grant_rd;
  logic               ack_sel;
  logic               expire;
  logic [31:0]        sel_addr;
  logic [31:0]        sel_slot;
  logic [31:0]        rdata_sel;
  logic [31:0]        slot_rdata [NUM_SLV];

  // The full upper address is compared so that addresses beyond the last slot decode as unmapped.
  assign sel_addr = grant_wr ? s_awaddr : s_araddr;
  assign sel_slot = sel_addr >> SLOT_SHIFT;

  assign wr_cand   = s_awvalid && s_wvalid;
  assign rd_cand   = s_arvalid;
  assign ack_sel   = mapped_reg && cfg_ack[slot_reg];
  assign rdata_sel = slot_rdata[slot_reg];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLV; gi++) begin : g_slot
      assign slot_rdata[gi] = cfg_rdata[32*gi +: 32];
      assign cfg_wr[gi] = (state_reg == ST_REQ) && mapped_reg && wr_reg
                          && (slot_reg == SEL_W'(gi));
      assign cfg_rd[gi] = (state_reg == ST_REQ) && mapped_reg && !wr_reg
                          && (slot_reg == SEL_W'(gi));
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    grant_wr   = 1'b0;
    grant_rd   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        // Under contention the side not served last wins.
        if (wr_cand && (!rd_cand || !last_wr_reg)) begin
          grant_wr = 1'b1;
        end else if (rd_cand) begin
          grant_rd = 1'b1;
        end
        if (grant_wr || grant_rd) begin
          state_next = ST_REQ;
        end
      end
      ST_REQ:  state_next = mapped_reg ? ST_WAIT : ST_RESP;
      ST_WAIT: begin
        if (ack_sel || expire) begin
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        if (wr_reg ? s_bready : s_rready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (flr_assert || !sync_rst_n) begin
      state_next = ST_IDLE;
      grant_wr   = 1'b0;
      grant_rd   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!sync_rst_n) begin
      state_reg   <= ST_IDLE;
      wr_reg      <= 1'b0;
      last_wr_reg <= 1'b0;
      mapped_reg  <= 1'b0;
      slot_reg    <= '0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      wstrb_reg   <= '0;
      rdata_reg   <= '0;
      resp_reg    <= RESP_OKAY;
    end else begin
      state_reg <= state_next;
      if (grant_wr || grant_rd) begin
        wr_reg      <= grant_wr;
        last_wr_reg <= grant_wr;
        addr_reg    <= sel_addr;
        mapped_reg  <= (sel_slot < 32'(NUM_SLV));
        slot_reg    <= sel_slot[SEL_W-1:0];
        if (grant_wr) begin
          wdata_reg <= s_wdata;
          wstrb_reg <= s_wstrb;
        end
      end
      if ((state_reg != ST_RESP) && (state_next == ST_RESP)) begin
        if (state_reg == ST_WAIT && ack_sel) begin
          rdata_reg <= rdata_sel;
          resp_reg  <= RESP_OKAY;
        end else if (state_reg == ST_WAIT) begin
          rdata_reg <= DEAD_DATA;
          resp_reg  <= RESP_SLVERR;
        end else begin
          rdata_reg <= DEAD_DATA;
          resp_reg  <= RESP_OKAY;
        end
      end
    end
  end

`ifdef CFG_MUX_TIMEOUT_EN
  logic [15:0] to_cnt_reg;
  logic        to_seen_reg;

  assign expire = (state_reg == ST_WAIT) && (to_cnt_reg == 16'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (!sync_rst_n) begin
      to_cnt_reg  <= '0;
      to_seen_reg <= 1'b0;
    end else begin
      if (state_reg == ST_REQ) begin
        to_cnt_reg <= '0;
      end else if (state_reg == ST_WAIT) begin
        to_cnt_reg <= to_cnt_reg + 16'd1;
      end
      if (expire && !ack_sel && !flr_assert) begin
        to_seen_reg <= 1'b1;
      end
    end
  end
`else
  assign expire = 1'b0;
`endif

  assign s_awready = grant_wr;
  assign s_wready  = grant_wr;
  assign s_arready = grant_rd;
  assign s_bvalid  = (state_reg == ST_RESP) && wr_reg;
  assign s_rvalid  = (state_reg == ST_RESP) && !wr_reg;
  assign s_bresp   = resp_reg;
  assign s_rresp   = resp_reg;
  assign s_rdata   = rdata_reg;
  assign cfg_addr  = addr_reg;
  assign cfg_wdata = wdata_reg;
  assign cfg_wstrb = wstrb_reg;

endmodule
